// File: rtl/cbs_window_pad_stream_pkg.sv
// Shared types and helpers for the CBS 3x3 window padding stream.
// A window is nine DATA_W taps packed row-major, p0 (top-left) in the MSBs.
package cbs_pkg;

    // Width of the row/column position counters and position tags.
    localparam int POS_W = 15;

    // Widest pixel the tap() helper can extract.
    localparam int TAP_MAX_W = 32;

    typedef enum logic {
        PAD_ZERO = 1'b0,
        PAD_REPL = 1'b1
    } pad_mode_e;

    // Return tap (r, c) of a window that has been zero-extended to
    // 9*TAP_MAX_W bits. The wanted pixel sits in the low data_w bits of the
    // result. The caller truncates the result to its own pixel width.
    function automatic logic [TAP_MAX_W-1:0] tap(
        input logic [9*TAP_MAX_W-1:0] win,
        input int                     r,
        input int                     c,
        input int                     data_w
    );
        logic [9*TAP_MAX_W-1:0] shifted;
        shifted = win >> (((2 - r) * 3 + (2 - c)) * data_w);
        return shifted[TAP_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/cbs_window_pad_stream_pos_counter.sv
// Window-centre position tracker for cbs_window_pad_stream.
// Reports the position of the window currently offered. An in_sof on that
// window forces the position to (0,0). The tracker also sets a sticky error
// when in_sof arrives away from (0,0), and flags on-grid, first and last
// windows for the selected stride.
module cbs_pos_counter
    import cbs_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 640,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic             sof,
    output logic [POS_W-1:0] pos_row,
    output logic [POS_W-1:0] pos_col,
    output logic             on_grid,
    output logic             is_first,
    output logic             is_last,
    output logic             err_sync
);

    localparam logic [POS_W-1:0] LAST_ROW  = POS_W'(IMG_H - 1);
    localparam logic [POS_W-1:0] LAST_COL  = POS_W'(IMG_W - 1);
    localparam logic [POS_W-1:0] FINAL_ROW = POS_W'(((IMG_H - 1) / STRIDE) * STRIDE);
    localparam logic [POS_W-1:0] FINAL_COL = POS_W'(((IMG_W - 1) / STRIDE) * STRIDE);

    logic [POS_W-1:0] row_q;
    logic [POS_W-1:0] col_q;

    // Effective position of the offered window, and its grid, first and last flags.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave a latch behind.
        pos_row  = row_q;
        pos_col  = col_q;
        on_grid  = 1'b1;
        is_first = 1'b0;
        is_last  = 1'b0;
        if (sof) begin
            pos_row = '0;
            pos_col = '0;
        end
        if (STRIDE == 2) begin
            on_grid = ~pos_row[0] & ~pos_col[0];
        end
        is_first = (pos_row == '0) && (pos_col == '0);
        is_last  = (pos_row == FINAL_ROW) && (pos_col == FINAL_COL);
    end

    // Advance the raster position on every accepted window; latch sync errors.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            row_q    <= '0;
            col_q    <= '0;
            err_sync <= 1'b0;
        end else if (accept) begin
            if (sof && (row_q != '0 || col_q != '0)) begin
                err_sync <= 1'b1;
            end
            if (pos_col == LAST_COL) begin
                col_q <= '0;
                row_q <= (pos_row == LAST_ROW) ? '0 : pos_row + 1'b1;
            end else begin
                col_q <= pos_col + 1'b1;
                row_q <= pos_row;
            end
        end
    end

endmodule

// File: rtl/cbs_window_pad_stream.sv
// CBS 3x3 window padding stage with stride decimation and a valid/ready stream.
// The stage takes bare windows, tracks the window-centre position itself,
// and pads out-of-image taps with zeros or edge replication. It also drops
// off-grid windows and holds the result in a single output register.
// Optional: define CBS_PAD_POS_TAG_EN to add the out_row/out_col position tags.
module cbs_window_pad_stream
    import cbs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 640,
    parameter int STRIDE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9*DATA_W-1:0] in_win,
    input  logic                in_sof,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                pad_mode,
    output logic [9*DATA_W-1:0] out_win,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_first,
    output logic                out_last,
    output logic                err_sync
`ifdef CBS_PAD_POS_TAG_EN
    ,
    output logic [POS_W-1:0]    out_row,
    output logic [POS_W-1:0]    out_col
`endif
);

    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(IMG_H - 1);
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(IMG_W - 1);

    logic                accept;
    logic [POS_W-1:0]    pos_row;
    logic [POS_W-1:0]    pos_col;
    logic                on_grid;
    logic                is_first;
    logic                is_last;
    pad_mode_e           mode_q;
    pad_mode_e           win_mode;
    logic [9*DATA_W-1:0] padded_win;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    cbs_pos_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .STRIDE (STRIDE)
    ) u_pos (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept),
        .sof      (in_sof),
        .pos_row  (pos_row),
        .pos_col  (pos_col),
        .on_grid  (on_grid),
        .is_first (is_first),
        .is_last  (is_last),
        .err_sync (err_sync)
    );

    // The (0,0) window uses the live pad_mode. Later windows use the latched copy.
    assign win_mode = is_first ? pad_mode_e'(pad_mode) : mode_q;

    // Latch the padding mode when a frame's first window is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= PAD_ZERO;
        end else if (accept && is_first) begin
            mode_q <= pad_mode_e'(pad_mode);
        end
    end

    // Pad mux: zero out-of-image taps, or replicate rows first, then columns.
    always_comb begin
        logic [9*TAP_MAX_W-1:0] win_ext;
        logic [DATA_W-1:0]      px [3][3];
        logic [DATA_W-1:0]      rc [3][3];
        logic [DATA_W-1:0]      pw [3][3];
        logic [2:0]             row_miss;
        logic [2:0]             col_miss;

        win_ext               = '0;
        win_ext[9*DATA_W-1:0] = in_win;
        padded_win            = '0;
        row_miss = {pos_row == LAST_ROW, 1'b0, pos_row == '0};
        col_miss = {pos_col == LAST_COL, 1'b0, pos_col == '0};

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                px[r][c] = DATA_W'(tap(win_ext, r, c, DATA_W));
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                rc[r][c] = row_miss[r] ? px[1][c] : px[r][c];
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (win_mode == PAD_ZERO) begin
                    pw[r][c] = (row_miss[r] || col_miss[c]) ? '0 : px[r][c];
                end else begin
                    pw[r][c] = col_miss[c] ? rc[r][1] : rc[r][c];
                end
                padded_win[(8 - (r * 3 + c)) * DATA_W +: DATA_W] = pw[r][c];
            end
        end
    end

    // Output register: load on-grid windows, drop off-grid ones, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_win   <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
`ifdef CBS_PAD_POS_TAG_EN
            out_row   <= '0;
            out_col   <= '0;
`endif
        end else if (accept) begin
            out_valid <= on_grid;
            if (on_grid) begin
                out_win   <= padded_win;
                out_first <= is_first;
                out_last  <= is_last;
`ifdef CBS_PAD_POS_TAG_EN
                out_row   <= pos_row;
                out_col   <= pos_col;
`endif
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cbs_window_pad_stream.sv
// Self-checking bench for cbs_window_pad_stream on a 4x3 image.
// One instance uses stride 1 and another uses stride 2; both share the input stream.
module tb_cbs_window_pad_stream;

    localparam int DW   = 8;
    localparam int IW   = 4;
    localparam int IH   = 3;
    localparam int NPIX = IW * IH;

    localparam logic [71:0] WIN       = 72'h11_22_33_44_55_66_77_88_99;
    localparam logic [71:0] ZERO_TL   = 72'h00_00_00_00_55_66_00_88_99;
    localparam logic [71:0] REPL_TL   = 72'h55_55_66_55_55_66_88_88_99;
    localparam logic [71:0] ZERO_BR   = 72'h11_22_00_44_55_00_00_00_00;

    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] in_win;
    logic        in_sof, in_valid, pad_mode, out_ready;

    logic        in_ready1, out_valid1, out_first1, out_last1, err_sync1;
    logic [71:0] out_win1;
    logic        in_ready2, out_valid2, out_first2, out_last2, err_sync2;
    logic [71:0] out_win2;
`ifdef CBS_PAD_POS_TAG_EN
    logic [14:0] out_row1, out_col1, out_row2, out_col2;
`endif

    typedef struct {
        logic [71:0] win;
        logic        first;
        logic        last;
        int          r;
        int          c;
    } exp_t;

    exp_t q[$];
    int   m_row, m_col;
    logic m_mode, m_err;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    always #5 clk = ~clk;

    cbs_window_pad_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .STRIDE(1)) dut1 (
        .clk(clk), .reset(reset), .in_win(in_win), .in_sof(in_sof), .in_valid(in_valid),
        .in_ready(in_ready1), .pad_mode(pad_mode), .out_win(out_win1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_first(out_first1), .out_last(out_last1), .err_sync(err_sync1)
`ifdef CBS_PAD_POS_TAG_EN
        , .out_row(out_row1), .out_col(out_col1)
`endif
    );

    cbs_window_pad_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .STRIDE(2)) dut2 (
        .clk(clk), .reset(reset), .in_win(in_win), .in_sof(in_sof), .in_valid(in_valid),
        .in_ready(in_ready2), .pad_mode(pad_mode), .out_win(out_win2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_first(out_first2), .out_last(out_last2), .err_sync(err_sync2)
`ifdef CBS_PAD_POS_TAG_EN
        , .out_row(out_row2), .out_col(out_col2)
`endif
    );

    // Reference padding: each output tap reads the in-image tap nearest to it
    // (replicate) or reads zero when it falls outside the image (zero pad).
    function automatic logic [71:0] pad_model(input logic [71:0] w, input int row, input int col,
                                              input logic mode);
        logic [71:0] res;
        res = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int  ir, ic, sr, sc;
                bit  outside;
                logic [7:0] v;
                ir = row - 1 + r;
                ic = col - 1 + c;
                outside = (ir < 0) || (ir >= IH) || (ic < 0) || (ic >= IW);
                sr = (ir < 0 || ir >= IH) ? 1 : r;
                sc = (ic < 0 || ic >= IW) ? 1 : c;
                v = w[(8 - (sr * 3 + sc)) * 8 +: 8];
                if (!mode && outside) v = 8'h00;
                res[(8 - (r * 3 + c)) * 8 +: 8] = v;
            end
        end
        return res;
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'($urandom);
        return w;
    endfunction

    task automatic model_accept(input logic [71:0] w, input logic sof, input logic mode);
        int lin;
        if (sof) begin
            if (m_row != 0 || m_col != 0) m_err = 1'b1;
            m_row = 0;
            m_col = 0;
        end
        if (m_row == 0 && m_col == 0) m_mode = mode;
        q.push_back('{pad_model(w, m_row, m_col, m_mode), (m_row == 0 && m_col == 0),
                      (m_row == IH - 1 && m_col == IW - 1), m_row, m_col});
        lin   = (m_row * IW + m_col + 1) % NPIX;
        m_row = lin / IW;
        m_col = lin % IW;
    endtask

    task automatic model_clear();
        q.delete();
        m_row  = 0;
        m_col  = 0;
        m_err  = 1'b0;
        m_mode = 1'b0;
    endtask

    // One clock: apply inputs, score the stride-1 instance against the model, advance.
    task automatic step(input logic [71:0] w, input logic sof, input logic vld,
                        input logic mode, input logic ordy);
        bit   exp_v;
        exp_t e;
        in_win = w; in_sof = sof; in_valid = vld; pad_mode = mode; out_ready = ordy;
        #1;
        exp_v = (q.size() != 0);
        checks++;
        if (out_valid1 !== exp_v) begin
            errors++;
            $display("FAIL out_valid: got %b want %b", out_valid1, exp_v);
        end
        checks++;
        if (in_ready1 !== (!exp_v || ordy)) begin
            errors++;
            $display("FAIL in_ready: got %b want %b", in_ready1, (!exp_v || ordy));
        end
        checks++;
        if (err_sync1 !== m_err) begin
            errors++;
            $display("FAIL err_sync: got %b want %b", err_sync1, m_err);
        end
        if (exp_v) begin
            e = q[0];
            checks++;
            if (out_win1 !== e.win || out_first1 !== e.first || out_last1 !== e.last) begin
                errors++;
                $display("FAIL output at (%0d,%0d): got %h f%b l%b want %h f%b l%b", e.r, e.c,
                         out_win1, out_first1, out_last1, e.win, e.first, e.last);
            end
`ifdef CBS_PAD_POS_TAG_EN
            checks++;
            if (out_row1 !== 15'(e.r) || out_col1 !== 15'(e.c)) begin
                errors++;
                $display("FAIL pos tag: got (%0d,%0d) want (%0d,%0d)", out_row1, out_col1, e.r, e.c);
            end
`endif
            if (ordy) begin
                void'(q.pop_front());
                n_out++;
            end
        end
        if (vld && (!exp_v || ordy)) model_accept(w, sof, mode);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
        in_win = '0; pad_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid1 !== 1'b0 || out_win1 !== '0 || out_first1 !== 1'b0 || out_last1 !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got v%b %h f%b l%b want all zero",
                     out_valid1, out_win1, out_first1, out_last1);
        end
        checks++;
        if (err_sync1 !== 1'b0 || in_ready1 !== 1'b1 || out_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: got err%b rdy%b v2%b want 0 1 0", err_sync1, in_ready1, out_valid2);
        end
    endtask

    task automatic test_zero_corner();
        do_reset();
        step(WIN, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid1 !== 1'b1 || out_win1 !== ZERO_TL || out_first1 !== 1'b1) begin
            errors++;
            $display("FAIL zero (0,0): got v%b %h f%b want v1 %h f1", out_valid1, out_win1, out_first1, ZERO_TL);
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_repl_corner();
        do_reset();
        step(WIN, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (out_win1 !== REPL_TL || out_first1 !== 1'b1) begin
            errors++;
            $display("FAIL repl (0,0): got %h f%b want %h f1", out_win1, out_first1, REPL_TL);
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_zero_last();
        do_reset();
        for (int i = 0; i < 11; i++) step(WIN, i == 0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_last1 !== 1'b0) begin
            errors++;
            $display("FAIL early last at (2,2): got %b want 0", out_last1);
        end
        step(WIN, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_win1 !== ZERO_BR || out_last1 !== 1'b1 || out_first1 !== 1'b0) begin
            errors++;
            $display("FAIL zero (2,3): got %h l%b f%b want %h l1 f0", out_win1, out_last1, out_first1, ZERO_BR);
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        int          sent, n0;
        logic [71:0] hold;
        logic [71:0] w;
        bit          ordy;
        do_reset();
        sent = 0;
        n0   = n_out;
        hold = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            ordy = !(cyc >= 3 && cyc <= 5);
            if (cyc == 3) hold = out_win1;
            w = rand_win();
            if (sent < 12 && (q.size() == 0 || ordy)) begin
                step(w, sent == 0, 1'b1, 1'b0, ordy);
                sent++;
            end else begin
                step(w, 1'b0, sent < 12, 1'b0, ordy);
            end
            if (cyc >= 3 && cyc <= 5) begin
                checks++;
                if (out_win1 !== hold || in_ready1 !== 1'b0) begin
                    errors++;
                    $display("FAIL stall cycle %0d: got %h rdy%b want %h rdy0", cyc, out_win1, in_ready1, hold);
                end
            end
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (n_out - n0 !== 12) begin
            errors++;
            $display("FAIL stall output count: got %0d want 12", n_out - n0);
        end
    endtask

    task automatic test_stride2();
        int          cnt2, r, c;
        bit          on;
        logic        mode;
        logic [71:0] w;
        do_reset();
        cnt2 = 0;
        mode = 1'($urandom);
        for (int i = 0; i < NPIX; i++) begin
            w = rand_win();
            r = i / IW;
            c = i % IW;
            step(w, i == 0, 1'b1, mode, 1'b1);
            on = (r % 2 == 0) && (c % 2 == 0);
            if (out_valid2 === 1'b1) cnt2++;
            checks++;
            if (out_valid2 !== on) begin
                errors++;
                $display("FAIL stride2 valid at (%0d,%0d): got %b want %b", r, c, out_valid2, on);
            end
            if (on) begin
                checks++;
                if (out_win2 !== pad_model(w, r, c, mode) || out_first2 !== (r == 0 && c == 0) ||
                    out_last2 !== (r == 2 && c == 2)) begin
                    errors++;
                    $display("FAIL stride2 output at (%0d,%0d): got %h f%b l%b want %h", r, c,
                             out_win2, out_first2, out_last2, pad_model(w, r, c, mode));
                end
            end
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (cnt2 !== 4 || out_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL stride2 count: got %0d v%b want 4 v0", cnt2, out_valid2);
        end
    endtask

    task automatic test_err_sync();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(WIN, (i == 0 || i == 4), 1'b1, 1'b0, 1'b1);
            if (i == 4) begin
                checks++;
                if (err_sync1 !== 1'b1 || out_first1 !== 1'b1 || out_win1 !== ZERO_TL) begin
                    errors++;
                    $display("FAIL resync window: got err%b f%b %h want err1 f1 %h",
                             err_sync1, out_first1, out_win1, ZERO_TL);
                end
            end
        end
        checks++;
        if (err_sync1 !== 1'b1) begin
            errors++;
            $display("FAIL err_sync sticky: got %b want 1", err_sync1);
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_mode_latch();
        do_reset();
        for (int i = 0; i < NPIX; i++) step(WIN, i == 0, 1'b1, i != 0, 1'b1);
        checks++;
        if (out_win1 !== ZERO_BR) begin
            errors++;
            $display("FAIL mode held mid-frame: got %h want %h", out_win1, ZERO_BR);
        end
        step(WIN, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (out_win1 !== REPL_TL || out_first1 !== 1'b1) begin
            errors++;
            $display("FAIL mode at next frame: got %h f%b want %h f1", out_win1, out_first1, REPL_TL);
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(WIN, 1'b1, 1'b1, 1'b0, 1'b0);
        step(WIN, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL held before reset: got v%b want 1", out_valid1);
        end
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        checks++;
        if (out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL mid-frame reset: got v%b want 0", out_valid1);
        end
        step(WIN, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_first1 !== 1'b1 || out_win1 !== ZERO_TL) begin
            errors++;
            $display("FAIL restart at (0,0): got f%b %h want f1 %h", out_first1, out_win1, ZERO_TL);
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(rand_win(), ($urandom % 13) == 0, ($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0);
        end
        repeat (3) step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_zero_corner();
        test_repl_corner();
        test_zero_last();
        test_stall();
        test_stride2();
        test_err_sync();
        test_mode_latch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
